ex_mem_stage: RTL
=================

# ex_mem_stage

Parametrised EX/MEM pipeline register for the five-stage MIPS core. It supersedes the fixed-width EX/MEM latch and carries the load/store fields (aluop, address, store data) and the PC. It also provides a synchronous flush for exception/branch squash. It feeds multi-cycle arithmetic state (accumulate temp and cycle count) back to EX while EX is stalled, and counts bubble cycles for performance monitoring.

## Interface
Parameters:
- DW, 32: datapath width (wdata, hi, lo, mem_addr, store data, pc).
- AW, 5: register-file address width.
- OPW, 8: aluop width.
- SW, 6: width of the stall vector.
- S, 3: stall bit index of this stage. Bit S+1 is the downstream (MEM) stage; requires S+1 < SW.
- CW, 16: width of the bubble-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash this stage's contents (exception/redirect).
- stall  in  SW  per-stage stall vector from the stall controller.
- ex_waddr  in  AW  destination register.
- ex_wdata  in  DW  result data.
- ex_wreg  in  1  register write enable.
- ex_whilo  in  1  HI/LO write enable.
- ex_hi, ex_lo  in  DW  HI/LO values.
- ex_aluop  in  OPW  operation code (consumed by MEM for loads/stores).
- ex_mem_addr  in  DW  effective address.
- ex_reg2  in  DW  store data.
- ex_pc  in  DW  instruction PC.
- ex_hilo_temp  in  2*DW  partial result of a multi-cycle op (madd/msub).
- ex_cnt  in  2  cycle index of a multi-cycle op.
- mem_waddr, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2, mem_pc  out  widths as inputs  registered copies to MEM.
- mem_valid  out  1  stage holds a real instruction (0 = bubble).
- hilo_temp_o  out  2*DW  held partial result back to EX.
- cnt_o  out  2  held cycle index back to EX.
- bubble_cnt  out  CW  saturating count of inserted bubbles.

## Operation
Per-cycle action, evaluated in strict priority order:
1. **rst.** All outputs go to 0, including bubble_cnt, hilo_temp_o and cnt_o. mem_wreg and mem_whilo are disabled; mem_valid = 0.
2. **flush.** Identical to reset for all payload outputs, mem_valid, hilo_temp_o and cnt_o. bubble_cnt is unchanged.
3. **Bubble** (stall[S]=1 and stall[S+1]=0):
   - All payload outputs are set to 0, with write enables disabled; mem_valid = 0.
   - hilo_temp_o <= ex_hilo_temp and cnt_o <= ex_cnt, so EX resumes the multi-cycle op next cycle.
   - bubble_cnt increments and saturates at 2^CW-1.
4. **Advance** (stall[S]=0):
   - All payload outputs take their ex_* values; mem_valid = 1.
   - hilo_temp_o and cnt_o clear to 0.
5. **Hold** (stall[S]=1 and stall[S+1]=1): every output keeps its value.

Rules and boundary conditions:
- mem_valid = 1 means an instruction was captured, including a NOP; it is not a function of ex_wreg.
- flush during a stall still clears the stage. This takes precedence over both hold and bubble.
- flush clears hilo_temp_o and cnt_o, which aborts any multi-cycle op in flight.
- A stall vector with stall[S]=0 and stall[S+1]=1 is illegal from the controller. The block treats it as Advance.
- After bubble_cnt reaches 2^CW-1, further bubbles leave it unchanged.

## Timing
- Latency: one cycle. ex_* inputs sampled at edge N appear on mem_* after edge N.
- No combinational path from any input to any output.
- hilo_temp_o and cnt_o are valid in the cycle after a bubble edge. EX samples them combinationally in that cycle.
- Reset takes effect on the first rising edge with rst=1. A reset in the middle of a multi-cycle op discards it.
- With sustained Hold, outputs are stable for any number of cycles. Release to Advance captures the current ex_* values.

## Test plan
- **Reset.** Drive rst=1 for 2 cycles with all ex_* nonzero. Required: all outputs 0, mem_valid=0, bubble_cnt=0.
- **Advance.** stall=0; ex_waddr=5'h1F, ex_wdata=32'hDEADBEEF, ex_wreg=1, ex_pc=32'h0000_0100. Required: the next cycle shows these same values on mem_*, with mem_valid=1, hilo_temp_o=0 and cnt_o=0.
- **Bubble with multi-cycle feedback.** stall=6'b001111 (S=3); ex_hilo_temp=64'h1234_5678_9ABC_DEF0; ex_cnt=2'b01. Required:
  - mem_wreg=0, mem_valid=0.
  - hilo_temp_o=64'h1234_5678_9ABC_DEF0, cnt_o=1.
  - bubble_cnt=1.
  - Next cycle, with stall=0: cnt_o=0 and payload captured.
- **Hold.** Load a value, then apply stall=6'b011111 for 3 cycles while changing ex_*. Required: outputs unchanged and bubble_cnt unchanged throughout.
- **Flush priority.** flush=1 together with stall=6'b011111 while mem_valid=1 and cnt_o=1. Required: all payload outputs 0, mem_valid=0, cnt_o=0, bubble_cnt unchanged.
- **Saturation.** Set CW=2 and apply 5 consecutive bubble cycles. Required: bubble_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: carries the EX result and load/store fields to MEM,
// feeds multi-cycle arithmetic state back to EX, and counts inserted bubbles.
module ex_mem_stage #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int OPW = 8,
  parameter int SW  = 6,
  parameter int S   = 3,
  parameter int CW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [SW-1:0]   stall,
  input  logic [AW-1:0]   ex_waddr,
  input  logic [DW-1:0]   ex_wdata,
  input  logic            ex_wreg,
  input  logic            ex_whilo,
  input  logic [DW-1:0]   ex_hi,
  input  logic [DW-1:0]   ex_lo,
  input  logic [OPW-1:0]  ex_aluop,
  input  logic [DW-1:0]   ex_mem_addr,
  input  logic [DW-1:0]   ex_reg2,
  input  logic [DW-1:0]   ex_pc,
  input  logic [2*DW-1:0] ex_hilo_temp,
  input  logic [1:0]      ex_cnt,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic            mem_wreg,
  output logic            mem_whilo,
  output logic [DW-1:0]   mem_hi,
  output logic [DW-1:0]   mem_lo,
  output logic [OPW-1:0]  mem_aluop,
  output logic [DW-1:0]   mem_mem_addr,
  output logic [DW-1:0]   mem_reg2,
  output logic [DW-1:0]   mem_pc,
  output logic            mem_valid,
  output logic [2*DW-1:0] hilo_temp_o,
  output logic [1:0]      cnt_o,
  output logic [CW-1:0]   bubble_cnt
);

  typedef struct packed {
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           wreg;
    logic           whilo;
    logic [DW-1:0]  hi;
    logic [DW-1:0]  lo;
    logic [OPW-1:0] aluop;
    logic [DW-1:0]  mem_addr;
    logic [DW-1:0]  reg2;
    logic [DW-1:0]  pc;
  } payload_t;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE,
    ACT_HOLD
  } act_t;

  act_t            act;
  payload_t        ex_pay;
  payload_t        pay_q, pay_d;
  logic            valid_q, valid_d;
  logic [2*DW-1:0] ht_q, ht_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [CW-1:0]   bc_q, bc_d;

  assign ex_pay = '{waddr: ex_waddr, wdata: ex_wdata, wreg: ex_wreg, whilo: ex_whilo,
                    hi: ex_hi, lo: ex_lo, aluop: ex_aluop, mem_addr: ex_mem_addr,
                    reg2: ex_reg2, pc: ex_pc};

  // stall[S]=0 with stall[S+1]=1 is not a legal controller output; it falls to Advance.
  always_comb begin
    act = ACT_HOLD;
    if (rst)
      act = ACT_RESET;
    else if (flush)
      act = ACT_FLUSH;
    else if (!stall[S])
      act = ACT_ADVANCE;
    else if (!stall[S+1])
      act = ACT_BUBBLE;
  end

  always_comb begin
    pay_d   = pay_q;
    valid_d = valid_q;
    ht_d    = ht_q;
    cnt_d   = cnt_q;
    bc_d    = bc_q;
    unique case (act)
      ACT_RESET: begin
        pay_d   = '0;
        valid_d = 1'b0;
        ht_d    = '0;
        cnt_d   = '0;
        bc_d    = '0;
      end
      ACT_FLUSH: begin
        pay_d   = '0;
        valid_d = 1'b0;
        ht_d    = '0;
        cnt_d   = '0;
      end
      ACT_BUBBLE: begin
        pay_d   = '0;
        valid_d = 1'b0;
        ht_d    = ex_hilo_temp;
        cnt_d   = ex_cnt;
        if (bc_q != '1)
          bc_d = bc_q + CW'(1);
      end
      ACT_ADVANCE: begin
        pay_d   = ex_pay;
        valid_d = 1'b1;
        ht_d    = '0;
        cnt_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    pay_q   <= pay_d;
    valid_q <= valid_d;
    ht_q    <= ht_d;
    cnt_q   <= cnt_d;
    bc_q    <= bc_d;
  end

  assign mem_waddr    = pay_q.waddr;
  assign mem_wdata    = pay_q.wdata;
  assign mem_wreg     = pay_q.wreg;
  assign mem_whilo    = pay_q.whilo;
  assign mem_hi       = pay_q.hi;
  assign mem_lo       = pay_q.lo;
  assign mem_aluop    = pay_q.aluop;
  assign mem_mem_addr = pay_q.mem_addr;
  assign mem_reg2     = pay_q.reg2;
  assign mem_pc       = pay_q.pc;
  assign mem_valid    = valid_q;
  assign hilo_temp_o  = ht_q;
  assign cnt_o        = cnt_q;
  assign bubble_cnt   = bc_q;

endmodule
